// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity encodings, the common
// TX/RX FSM state encoding and the parity helper used by both directions.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Bit that completes the word to the requested parity; narrower words are
    // zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible whenever the
// FIFO is not empty; a push into a full FIFO without a pop is dropped and flagged.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overrun_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             overrun_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the incoming word needs.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            overrun_q <= push_i && full_o && !do_pop;
        end
    end

    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_txrx_param.sv
// Full-duplex UART with configurable data width, parity and stop bits, valid/ready
// handshakes on both sides and an FWFT receive FIFO carrying per-word error flags.
module uart_txrx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 189,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    output logic                 TXD,
    input  logic                 RXD,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TX_BUSY,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_PARITY_ERR,
    output logic                 RX_FRAME_ERR,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 RX_OVERRUN,
    output logic                 RX_BUSY
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_MID   = CW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);
    localparam logic [1:0]     PAR_MODE  = 2'(PARITY);

    // ---------------- transmitter ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == CNT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        if (tx_state_q != ST_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        unique case (tx_state_q)
            ST_IDLE: begin
                if (TX_VALID) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = TX_DATA;
                    tx_par_d   = calc_parity(8'(TX_DATA), PAR_MODE);
                    txd_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_LAST) begin
                        if (PARITY != 0) begin
                            tx_state_d = ST_PARITY;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            tx_stop_d  = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = ST_STOP;
                    tx_stop_d  = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop_q == STOP_LAST) begin
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    assign TXD      = txd_q;
    assign TX_READY = (tx_state_q == ST_IDLE);
    assign TX_BUSY  = (tx_state_q != ST_IDLE);

    // ---------------- receiver ----------------
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    uart_state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic                 rx_stop_q, rx_stop_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_sample;
    logic                 rx_push;
    logic [DATA_BITS+1:0] rx_push_word;

    // Every state samples at mid-count, so one sample lands per bit period.
    assign rx_sample = (rx_cnt_q == CNT_MID);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_stop_d    = rx_stop_q;
        rx_shift_d   = rx_shift_q;
        rx_perr_d    = rx_perr_q;
        rx_ferr_d    = rx_ferr_q;
        rx_push      = 1'b0;
        rx_push_word = {rx_ferr_q, rx_perr_q, rx_shift_q};
        if (rx_state_q != ST_IDLE) begin
            rx_cnt_d = (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + 1'b1;
        end
        unique case (rx_state_q)
            ST_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = '0;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (rx_sample) begin
                    if (rxd_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        rx_stop_d  = 1'b0;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = (rxd_sync_q != calc_parity(8'(rx_shift_q), PAR_MODE));
                    rx_state_d = ST_STOP;
                    rx_stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (rx_sample) begin
                    rx_ferr_d = rx_ferr_q | ~rxd_sync_q;
                    if (rx_stop_q == STOP_LAST) begin
                        rx_push      = 1'b1;
                        rx_push_word = {rx_ferr_d, rx_perr_q, rx_shift_q};
                        rx_state_d   = ST_IDLE;
                    end else begin
                        rx_stop_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_stop_q  <= 1'b0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_stop_q  <= rx_stop_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign RX_BUSY = (rx_state_q != ST_IDLE);

    logic [DATA_BITS+1:0] fifo_rdata;
    logic                 fifo_empty;
    logic                 rx_fifo_full_unused;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i     (CLK),
        .srst_i    (RESET),
        .push_i    (rx_push),
        .wdata_i   (rx_push_word),
        .pop_i     (RX_READY),
        .rdata_o   (fifo_rdata),
        .empty_o   (fifo_empty),
        .full_o    (rx_fifo_full_unused),
        .overrun_o (RX_OVERRUN)
    );

    assign {RX_FRAME_ERR, RX_PARITY_ERR, RX_DATA} = fifo_rdata;
    assign RX_VALID = !fifo_empty;

endmodule

// File: tb/tb_uart_txrx_param.sv
// Bench for uart_txrx_param: three instances (8N1 direct, 8E1 loopback, 7O2 direct)
// exercised with vector tables, hand sequences and scoreboard queues.
`timescale 1ns/1ps
module tb_uart_txrx_param;

    localparam int CPB = 16;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    // Instance A: 8N1, RXD driven by the bench
    logic [7:0] a_tx_data, a_rx_data;
    logic a_tx_valid, a_txd, a_tx_ready, a_tx_busy, a_rxd;
    logic a_rx_perr, a_rx_ferr, a_rx_valid, a_rx_ready, a_rx_ovr, a_rx_busy;
    // Instance B: 8E1, TXD looped back to RXD
    logic [7:0] b_tx_data, b_rx_data;
    logic b_tx_valid, b_txd, b_tx_ready, b_tx_busy;
    logic b_rx_perr, b_rx_ferr, b_rx_valid, b_rx_ready, b_rx_ovr, b_rx_busy;
    // Instance C: 7O2, RXD driven by the bench
    logic [6:0] c_tx_data, c_rx_data;
    logic c_tx_valid, c_txd, c_tx_ready, c_tx_busy, c_rxd;
    logic c_rx_perr, c_rx_ferr, c_rx_valid, c_rx_ready, c_rx_ovr, c_rx_busy;

    uart_txrx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
        .CLK(CLK), .RESET(RESET), .TXD(a_txd), .RXD(a_rxd),
        .TX_DATA(a_tx_data), .TX_VALID(a_tx_valid), .TX_READY(a_tx_ready), .TX_BUSY(a_tx_busy),
        .RX_DATA(a_rx_data), .RX_PARITY_ERR(a_rx_perr), .RX_FRAME_ERR(a_rx_ferr), .RX_VALID(a_rx_valid),
        .RX_READY(a_rx_ready), .RX_OVERRUN(a_rx_ovr), .RX_BUSY(a_rx_busy));

    uart_txrx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_b (
        .CLK(CLK), .RESET(RESET), .TXD(b_txd), .RXD(b_txd),
        .TX_DATA(b_tx_data), .TX_VALID(b_tx_valid), .TX_READY(b_tx_ready), .TX_BUSY(b_tx_busy),
        .RX_DATA(b_rx_data), .RX_PARITY_ERR(b_rx_perr), .RX_FRAME_ERR(b_rx_ferr), .RX_VALID(b_rx_valid),
        .RX_READY(b_rx_ready), .RX_OVERRUN(b_rx_ovr), .RX_BUSY(b_rx_busy));

    uart_txrx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .RX_FIFO_DEPTH(2)) u_c (
        .CLK(CLK), .RESET(RESET), .TXD(c_txd), .RXD(c_rxd),
        .TX_DATA(c_tx_data), .TX_VALID(c_tx_valid), .TX_READY(c_tx_ready), .TX_BUSY(c_tx_busy),
        .RX_DATA(c_rx_data), .RX_PARITY_ERR(c_rx_perr), .RX_FRAME_ERR(c_rx_ferr), .RX_VALID(c_rx_valid),
        .RX_READY(c_rx_ready), .RX_OVERRUN(c_rx_ovr), .RX_BUSY(c_rx_busy));

    typedef struct {
        logic [7:0] data;
        logic       par;
    } b_vec_t;

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic       stop1;
        logic       stop2;
        logic       perr;
        logic       ferr;
    } c_vec_t;

    int n_total = 0;
    int n_pass  = 0;
    int cyc = 0;
    int a_ovr_cnt = 0;
    int a_ovr_cyc = 0;
    logic a_busy_seen = 1'b0;

    logic [9:0] sb_a[$];
    logic [9:0] sb_b[$];
    logic [8:0] sb_c[$];
    b_vec_t b_tab[6];
    c_vec_t c_tab[4];

    logic [9:0] exp_a;
    logic [8:0] exp_c;
    int gap, period, start5, exp_ovr, off;
    logic seen_idle, got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (a_rx_ovr) begin
            a_ovr_cnt++;
            a_ovr_cyc = cyc;
        end
        if (a_rx_busy) a_busy_seen = 1'b1;
    endtask

    function automatic logic [15:0] a_frame(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    task automatic drive_bits(input bit to_c, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (to_c) c_rxd = bits[i];
            else a_rxd = bits[i];
            repeat (CPB) tick();
        end
        if (to_c) c_rxd = 1'b1;
        else a_rxd = 1'b1;
    endtask

    // Send one 8N1 word on A and check every bit period of TXD plus the handshakes.
    task automatic tx_frame_a(input logic [7:0] data);
        logic [9:0]  frame;
        logic [15:0] lvl;
        int ready_low, busy_ok;
        frame = {1'b1, data, 1'b0};
        ready_low = 0;
        busy_ok = 0;
        check("tx_ready_before", 32'(a_tx_ready), 1);
        a_tx_data = data;
        a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        a_tx_data = ~data;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < CPB; j++) begin
                lvl[j] = a_txd;
                if (!a_tx_ready) ready_low++;
                if (a_tx_busy == !a_tx_ready) busy_ok++;
                tick();
            end
            check($sformatf("txd_bit%0d", b), 32'(lvl), frame[b] ? 32'hFFFF : 32'h0);
        end
        check("tx_ready_low_cycles", ready_low, 10 * CPB);
        check("tx_busy_tracks", busy_ok, 10 * CPB);
        check("tx_ready_after", 32'(a_tx_ready), 1);
        check("txd_idle_after", 32'(a_txd), 1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_txd"}, 32'(a_txd), 1);
        check({tag, "_tx_ready"}, 32'(a_tx_ready), 1);
        check({tag, "_tx_busy"}, 32'(a_tx_busy), 0);
        check({tag, "_rx_valid"}, 32'(a_rx_valid), 0);
        check({tag, "_rx_busy"}, 32'(a_rx_busy), 0);
        check({tag, "_rx_ovr"}, 32'(a_rx_ovr), 0);
        check({tag, "_rx_word"}, 32'({a_rx_ferr, a_rx_perr, a_rx_data}), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_tx_data = '0; a_tx_valid = 1'b0; a_rxd = 1'b1; a_rx_ready = 1'b0;
        b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b0;
        c_tx_data = '0; c_tx_valid = 1'b0; c_rxd = 1'b1; c_rx_ready = 1'b0;

        b_tab[0] = '{8'h37, 1'b1};
        b_tab[1] = '{8'h00, 1'b0};
        b_tab[2] = '{8'hFF, 1'b0};
        b_tab[3] = '{8'h80, 1'b1};
        b_tab[4] = '{8'h5A, 1'b0};
        b_tab[5] = '{8'h01, 1'b1};

        c_tab[0] = '{7'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        c_tab[1] = '{7'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        c_tab[2] = '{7'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        c_tab[3] = '{7'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        RESET = 1'b1;
        repeat (3) tick();
        reset_checks("reset");
        check("reset_b_rx_valid", 32'(b_rx_valid), 0);
        check("reset_c_rx_valid", 32'(c_rx_valid), 0);
        RESET = 1'b0;
        tick();

        // TX bit pattern and handshake timing, data changed after acceptance
        tx_frame_a(8'hA5);

        // Back-to-back frames with TX_VALID held: one idle cycle between frames
        a_tx_data = 8'h3C;
        a_tx_valid = 1'b1;
        tick();
        gap = 0; period = 0; seen_idle = 1'b0;
        for (int k = 0; k < 400 && !(seen_idle && a_tx_busy); k++) begin
            if (!a_tx_busy) begin
                gap++;
                seen_idle = 1'b1;
                check("b2b_idle_txd", 32'(a_txd), 1);
            end
            period++;
            tick();
        end
        a_tx_valid = 1'b0;
        check("b2b_idle_gap", gap, 1);
        check("b2b_start_to_start", period, 10 * CPB + 1);
        for (int k = 0; k < 400 && !a_tx_ready; k++) tick();
        check("b2b_done_ready", 32'(a_tx_ready), 1);

        // Short low glitch: false start, nothing pushed
        a_busy_seen = 1'b0;
        a_rxd = 1'b0;
        repeat (3) tick();
        a_rxd = 1'b1;
        repeat (40) tick();
        check("glitch_busy_pulsed", 32'(a_busy_seen), 1);
        check("glitch_busy_cleared", 32'(a_rx_busy), 0);
        check("glitch_no_push", 32'(a_rx_valid), 0);
        drive_bits(1'b0, a_frame(8'h5A), 10);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (a_rx_valid) got = 1'b1;
            else tick();
        end
        check("post_glitch_valid", 32'(got), 1);
        check("post_glitch_word", 32'({a_rx_ferr, a_rx_perr, a_rx_data}), 32'h05A);
        a_rx_ready = 1'b1;
        tick();
        a_rx_ready = 1'b0;
        check("post_glitch_popped", 32'(a_rx_valid), 0);

        // Fill the 4-deep FIFO and overflow it once; scoreboard models capacity
        a_ovr_cnt = 0;
        exp_ovr = 0;
        start5 = 0;
        for (int f = 1; f <= 5; f++) begin
            if (f == 5) start5 = cyc;
            if (sb_a.size() < 4) sb_a.push_back({2'b00, 8'(f)});
            else exp_ovr++;
            drive_bits(1'b0, a_frame(8'(f)), 10);
        end
        repeat (5) tick();
        check("overrun_pulses", a_ovr_cnt, exp_ovr);
        off = a_ovr_cyc - start5;
        check("overrun_in_fifth_stop", 32'(off >= 9 * CPB && off <= 10 * CPB + 2), 1);
        a_rx_ready = 1'b1;
        for (int k = 0; k < 8 && a_rx_valid; k++) begin
            if (sb_a.size() == 0) begin
                check("rx_unexpected_word", 32'(a_rx_valid), 0);
                break;
            end
            exp_a = sb_a.pop_front();
            check("rx_fifo_word", 32'({a_rx_ferr, a_rx_perr, a_rx_data}), 32'(exp_a));
            tick();
        end
        a_rx_ready = 1'b0;
        check("rx_fifo_drained", 32'(a_rx_valid), 0);
        check("rx_scoreboard_empty", sb_a.size(), 0);

        // Reset mid-TX with two words queued in the FIFO
        drive_bits(1'b0, a_frame(8'h11), 10);
        drive_bits(1'b0, a_frame(8'h22), 10);
        check("pre_reset_valid", 32'(a_rx_valid), 1);
        check("pre_reset_head", 32'(a_rx_data), 32'h11);
        a_tx_data = 8'hC3;
        a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        repeat (50) tick();
        check("pre_reset_tx_busy", 32'(a_tx_busy), 1);
        RESET = 1'b1;
        tick();
        reset_checks("midreset");
        RESET = 1'b0;
        tick();
        tx_frame_a(8'h96);

        // 8E1 loopback vectors: parity bit on the wire and the received word
        for (int v = 0; v < 6; v++) begin
            sb_b.push_back({2'b00, b_tab[v].data});
            b_tx_data = b_tab[v].data;
            b_tx_valid = 1'b1;
            tick();
            b_tx_valid = 1'b0;
            repeat (9 * CPB + 7) tick();
            check($sformatf("b_parity_bit_%0h", b_tab[v].data), 32'(b_txd), 32'(b_tab[v].par));
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                if (b_rx_valid) got = 1'b1;
                else tick();
            end
            check("b_rx_valid", 32'(got), 1);
            if (got) begin
                exp_a = sb_b.pop_front();
                check($sformatf("b_rx_word_%0h", b_tab[v].data),
                      32'({b_rx_ferr, b_rx_perr, b_rx_data}), 32'(exp_a));
                b_rx_ready = 1'b1;
                tick();
                b_rx_ready = 1'b0;
            end
            for (int k = 0; k < 100 && !b_tx_ready; k++) tick();
        end
        check("b_no_overrun_or_leftover", 32'(b_rx_valid), 0);

        // 7O2 receive vectors: parity and framing flags
        for (int v = 0; v < 4; v++) begin
            sb_c.push_back({c_tab[v].ferr, c_tab[v].perr, c_tab[v].data});
            drive_bits(1'b1, {5'b0, c_tab[v].stop2, c_tab[v].stop1, c_tab[v].par,
                              c_tab[v].data, 1'b0}, 11);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                if (c_rx_valid) got = 1'b1;
                else tick();
            end
            check("c_rx_valid", 32'(got), 1);
            if (got) begin
                exp_c = sb_c.pop_front();
                check($sformatf("c_rx_word%0d", v), 32'({c_rx_ferr, c_rx_perr, c_rx_data}), 32'(exp_c));
                c_rx_ready = 1'b1;
                tick();
                c_rx_ready = 1'b0;
            end
            repeat (CPB) tick();
        end
        check("c_rx_empty", 32'(c_rx_valid), 0);
        check("c_tx_idle", 32'({c_txd, c_tx_ready, c_tx_busy}), 32'b110);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
